// File: rtl/bp_burst_to_lite.sv
// Reassembles a burst stream (header plus data beats) into a single lite {header, data} message.
// Header layout: {payload, addr[paddr_width_p], size[2:0], msg_type[3:0]}; BP_BURST_TO_LITE_OVERLAP_EN enables zero-bubble back-to-back messages.
module bp_burst_to_lite
  #(parameter int          paddr_width_p    = 40
  , parameter int          in_data_width_p  = 64
  , parameter int          out_data_width_p = 512
  , parameter int          payload_width_p  = 0
  , parameter logic [15:0] payload_mask_p   = '0
  , localparam int in_msg_header_width_lp = payload_width_p + paddr_width_p + 7
  , localparam int out_msg_width_lp       = in_msg_header_width_lp + out_data_width_p
  )
  (input  logic                              clk_i
  , input  logic                              reset_n_i
  , input  logic [in_msg_header_width_lp-1:0] in_msg_header_i
  , input  logic                              in_msg_header_v_i
  , output logic                              in_msg_header_ready_and_o
  , input  logic [in_data_width_p-1:0]        in_msg_data_i
  , input  logic                              in_msg_data_v_i
  , output logic                              in_msg_data_ready_and_o
  , output logic [out_msg_width_lp-1:0]       out_msg_o
  , output logic                              out_msg_v_o
  , input  logic                              out_msg_ready_and_i
  );

  localparam int unsigned max_beats_lp = out_data_width_p / in_data_width_p;
  localparam int unsigned in_bytes_lp  = in_data_width_p / 8;
  localparam int          cnt_w_lp     = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;

  typedef enum logic [1:0] {e_ready, e_data, e_out} state_e;

  state_e                            state;
  logic [cnt_w_lp-1:0]               cnt;
  logic [in_msg_header_width_lp-1:0] header_r;
  logic [out_data_width_p-1:0]       data_r;
  int unsigned                       beats_n;
  logic                              hdr_rdy, hdr_hs, data_hs, out_hs;

  function automatic int unsigned num_beats(input logic [2:0] sz);
    int unsigned b;
    b = (32'd1 << sz) / in_bytes_lp;
    if (b == 0) b = 1;
    if (b > max_beats_lp) b = max_beats_lp;
    return b;
  endfunction

  always_comb beats_n = num_beats(header_r[6:4]);

`ifdef BP_BURST_TO_LITE_OVERLAP_EN
  assign hdr_rdy = (state == e_ready) | ((state == e_out) & out_msg_ready_and_i);
`else
  assign hdr_rdy = (state == e_ready);
`endif

  // Outputs are decoded from registered state; gating with reset_n_i forces them low during reset.
  assign in_msg_header_ready_and_o = reset_n_i & hdr_rdy;
  assign in_msg_data_ready_and_o   = reset_n_i & (state == e_data);
  assign out_msg_v_o               = reset_n_i & (state == e_out);
  assign out_msg_o                 = {header_r, data_r};

  assign hdr_hs  = in_msg_header_v_i & in_msg_header_ready_and_o;
  assign data_hs = in_msg_data_v_i   & in_msg_data_ready_and_o;
  assign out_hs  = out_msg_ready_and_i & out_msg_v_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= e_ready;
      cnt      <= '0;
      header_r <= '0;
      data_r   <= '0;
    end else if (hdr_hs) begin
      // Clearing data here makes no-data messages present zeros.
      header_r <= in_msg_header_i;
      data_r   <= '0;
      cnt      <= '0;
      state    <= payload_mask_p[in_msg_header_i[3:0]] ? e_data : e_out;
    end else begin
      unique case (state)
        e_data: if (data_hs) begin
          // Each beat lands in every slot it replicates into, so the output needs no mux.
          for (int unsigned j = 0; j < max_beats_lp; j++)
            if ((j % beats_n) == 32'(cnt))
              data_r[j*in_data_width_p +: in_data_width_p] <= in_msg_data_i;
          cnt <= cnt + 1'b1;
          if (32'(cnt) == beats_n - 1) state <= e_out;
        end
        e_out: if (out_hs) state <= e_ready;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_burst_to_lite.sv
// Randomized and directed bench for bp_burst_to_lite with a queue-based message model.
module tb_bp_burst_to_lite;
  localparam int HW = 47;
  localparam int IW = 64;
  localparam int OW = 512;
  localparam int MW = HW + OW;
  localparam logic [15:0] MASK = 16'h0116;
`ifdef BP_BURST_TO_LITE_OVERLAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  typedef logic [IW-1:0] beats_t [8];

  logic          clk = 0, rst_n = 0;
  logic [HW-1:0] hdr = '0;
  logic          hdr_v = 0, hdr_ready;
  logic [IW-1:0] data = '0;
  logic          data_v = 0, data_ready;
  logic [MW-1:0] out_msg;
  logic          out_v, out_ready = 0;

  bp_burst_to_lite #(.paddr_width_p(40), .in_data_width_p(IW), .out_data_width_p(OW),
                     .payload_width_p(0), .payload_mask_p(MASK)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .in_msg_header_i(hdr), .in_msg_header_v_i(hdr_v), .in_msg_header_ready_and_o(hdr_ready),
    .in_msg_data_i(data), .in_msg_data_v_i(data_v), .in_msg_data_ready_and_o(data_ready),
    .out_msg_o(out_msg), .out_msg_v_o(out_v), .out_msg_ready_and_i(out_ready));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [HW-1:0] hq[$];
  logic [IW-1:0] bq[$];
  logic [MW-1:0] exp_q[$];
  int pop_cyc[$];
  bit gaps = 0;
  int sink_mode = 0;
  int hdr_hs_cyc = 0, beat_hs_cyc = 0, rise_cyc = -1;
  logic [MW-1:0] last_msg = '0;
  bit prev_v = 0;

  task automatic check(input string nm, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no handshake/unexpected event, required completion", nm);
  endtask

  function automatic int unsigned n_beats(input logic [HW-1:0] h);
    int unsigned n;
    n = (32'd1 << h[6:4]) / (IW / 8);
    if (n < 1) n = 1;
    if (n > 8) n = 8;
    return n;
  endfunction

  // Lite data: the n collected beats repeated across the word, zero for no-data types.
  function automatic logic [OW-1:0] model_data(input logic [HW-1:0] h, input beats_t b);
    logic [OW-1:0] d;
    int unsigned n;
    d = '0;
    n = n_beats(h);
    if (MASK[h[3:0]])
      for (int unsigned j = 0; j < 8; j++) d[j*IW +: IW] = b[j % n];
    return d;
  endfunction

  task automatic queue_msg(input logic [HW-1:0] h, input beats_t b);
    hq.push_back(h);
    if (MASK[h[3:0]])
      for (int unsigned j = 0; j < n_beats(h); j++) bq.push_back(b[j]);
    exp_q.push_back({h, model_data(h, b)});
  endtask

  task automatic drive_hdrs();
    while (hq.size() > 0) begin
      int t;
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      hdr = hq.pop_front();
      hdr_v = 1;
      t = 0;
      @(negedge clk);
      while (!hdr_ready && t < 2000) begin t++; @(negedge clk); end
      if (!hdr_ready) begin fail_now("hdr_timeout"); hq.delete(); end
      else hdr_hs_cyc = cyc + 1;
      @(posedge clk); #1;
      hdr_v = 0;
    end
  endtask

  task automatic drive_beats();
    while (bq.size() > 0) begin
      int t;
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      data = bq.pop_front();
      data_v = 1;
      t = 0;
      @(negedge clk);
      while (!data_ready && t < 2000) begin t++; @(negedge clk); end
      if (!data_ready) begin fail_now("beat_timeout"); bq.delete(); end
      else beat_hs_cyc = cyc + 1;
      @(posedge clk); #1;
      data_v = 0;
    end
  endtask

  task automatic drive_all();
    @(posedge clk); #1;
    fork
      drive_hdrs();
      drive_beats();
    join
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin @(negedge clk); t++; end
    if (exp_q.size() > 0) begin fail_now("drain_timeout"); exp_q.delete(); end
  endtask

  initial forever begin
    @(posedge clk); #1;
    out_ready = (sink_mode == 0) ? 1'b1 : (sink_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Compare process: every valid cycle the output must equal the oldest outstanding message.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_v) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_v");
        else begin
          check("out_msg", out_msg, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            pop_cyc.push_back(cyc + 1);
          end
        end
        if (!prev_v) begin
          rise_cyc <= cyc;
          last_msg <= out_msg;
        end
      end
      check("ready_exclusive", MW'(data_ready & (out_v | hdr_ready)), '0);
      prev_v <= out_v;
    end else prev_v <= 0;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    beats_t b;
    logic [HW-1:0] h;
    logic [MW-1:0] hold;
    logic [OW-1:0] rep;

    repeat (3) @(negedge clk);
    check("rst_hdr_ready", MW'(hdr_ready), '0);
    check("rst_data_ready", MW'(data_ready), '0);
    check("rst_out_v", MW'(out_v), '0);
    check("rst_out_msg", out_msg, '0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("idle_hdr_ready", MW'(hdr_ready), MW'(1));

    data = 64'h1111_2222_3333_4444;
    data_v = 1;
    repeat (3) begin @(negedge clk); check("idle_data_ready", MW'(data_ready), '0); end
    @(posedge clk); #1 data_v = 0;

    // No-data header: valid one cycle after the header, zero data, header bit-exact.
    for (int k = 0; k < 8; k++) b[k] = '0;
    h = {40'h12_3456_789A, 3'd3, 4'd0};
    queue_msg(h, b);
    drive_all();
    drain();
    check("nodata_latency", MW'(rise_cyc), MW'(hdr_hs_cyc));
    check("nodata_hdr", MW'(last_msg[MW-1:OW]), MW'(h));
    check("nodata_data", MW'(last_msg[OW-1:0]), '0);

    // 64B message: eight beats k land in slice k.
    for (int k = 0; k < 8; k++) b[k] = 64'(k);
    h = {40'h00_0000_1000, 3'd6, 4'd1};
    queue_msg(h, b);
    drive_all();
    drain();
    check("8beat_latency", MW'(rise_cyc), MW'(beat_hs_cyc));
    for (int k = 0; k < 8; k++) check("8beat_slice", MW'(last_msg[k*IW +: IW]), MW'(k));

    // 4B message: a single beat replicated across the lite word.
    b[0] = 64'hDEADBEEF_CAFEF00D;
    h = {40'h00_0000_2004, 3'd2, 4'd2};
    queue_msg(h, b);
    drive_all();
    drain();
    rep = {8{64'hDEADBEEF_CAFEF00D}};
    check("replicate", MW'(last_msg[OW-1:0]), MW'(rep));

    // Downstream stall: output holds, nothing else is accepted.
    sink_mode = 2;
    b[0] = 64'h5555_AAAA_1234_5678;
    h = {40'h00_0000_3000, 3'd3, 4'd4};
    queue_msg(h, b);
    drive_all();
    hdr = {40'h77_7777_7777, 3'd1, 4'd0};
    hdr_v = 1;
    data = 64'hBAD0_BAD0_BAD0_BAD0;
    data_v = 1;
    @(negedge clk);
    hold = out_msg;
    check("stall_hold_msg", hold, {h, {8{64'h5555_AAAA_1234_5678}}});
    repeat (20) begin
      @(negedge clk);
      check("stall_out_v", MW'(out_v), MW'(1));
      check("stall_stable", out_msg, hold);
      check("stall_hdr_ready", MW'(hdr_ready), '0);
      check("stall_data_ready", MW'(data_ready), '0);
    end
    @(posedge clk); #1;
    hdr_v = 0;
    data_v = 0;
    sink_mode = 0;
    drain();

    // Reset after three of eight beats: partial message discarded.
    hq.push_back({40'h00_0000_4000, 3'd6, 4'd1});
    for (int k = 0; k < 3; k++) bq.push_back(64'hA0 + 64'(k));
    drive_all();
    rst_n = 0;
    #1;
    check("midrst_hdr_ready", MW'(hdr_ready), '0);
    check("midrst_data_ready", MW'(data_ready), '0);
    check("midrst_out_v", MW'(out_v), '0);
    check("midrst_out_msg", out_msg, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int k = 0; k < 8; k++) b[k] = 64'h100 + 64'(k);
    h = {40'h00_0000_5000, 3'd6, 4'd8};
    queue_msg(h, b);
    drive_all();
    drain();
    check("postrst_latency", MW'(rise_cyc), MW'(beat_hs_cyc));
    for (int k = 0; k < 8; k++) check("postrst_slice", MW'(last_msg[k*IW +: IW]), MW'(64'h100 + 64'(k)));

    // Back-to-back no-data headers: spacing of output handshakes.
    pop_cyc.delete();
    for (int k = 0; k < 4; k++) queue_msg({40'(k), 3'(k), 4'd0}, b);
    drive_all();
    drain();
    check("b2b_count", MW'(pop_cyc.size()), MW'(4));
    if (pop_cyc.size() == 4)
      for (int k = 1; k < 4; k++) check("b2b_spacing", MW'(pop_cyc[k] - pop_cyc[k-1]), MW'(GAP));

    // Random traffic with valid gaps and random downstream backpressure.
    gaps = 1;
    sink_mode = 1;
    for (int m = 0; m < 60; m++) begin
      for (int k = 0; k < 8; k++) b[k] = {$urandom(), $urandom()};
      h = {40'({$urandom(), $urandom()}), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      queue_msg(h, b);
    end
    drive_all();
    drain();
    repeat (5) @(negedge clk);
    check("queue_empty", MW'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
